// File: rtl/jtopl_reg_chn.sv
// Channel-config register rings for an OPL-style slot sequencer.
// Each group of channels keeps its config words in a small circular ring.
// The ring of the current group rotates one position per slot advance, so
// the head word always belongs to the channel being visited. Writes are held
// pending and folded into the ring when their channel reaches the head. A
// 6-bit rhythm CSR rotates alongside to flag rhythm key-on per slot.
module jtopl_reg_chn #(
    parameter int CHCSRW   = 10,
    parameter int NGRP     = 3,
    parameter int STAGES   = 3,
    parameter int OEN_SLOT = 11,
    localparam int NCH     = NGRP * STAGES,
    localparam int NSLOT   = 2 * NCH,
    localparam int CW      = $clog2(NCH),
    localparam int SW      = $clog2(NSLOT),
    localparam int GW      = $clog2(NGRP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              rhy_en,
    input  logic [4:0]        rhy_kon,
    input  logic              wr_req,
    input  logic [CW-1:0]     wr_ch,
    input  logic [CHCSRW-1:0] wr_din,
    output logic              wr_busy,
    output logic              wr_ack,
    output logic [SW-1:0]     slot,
    output logic              zero,
    output logic [CW-1:0]     ch_idx,
    output logic [CHCSRW-1:0] chcfg,
    output logic              rhy_oen,
    output logic              rhyon_csr
);

    logic [SW-1:0]          slot_reg;
    logic [GW-1:0]          group;
    logic [NGRP*CHCSRW-1:0] heads;
    logic                   busy_reg;
    logic                   ack_reg;
    logic [CW-1:0]          pend_ch_reg;
    logic [CHCSRW-1:0]      pend_data_reg;
    logic [5:0]             rhy_csr_reg;
    logic                   rhy_oen_reg;
    logic                   commit;
    logic                   pend_bad;

    // Group and channel are pure functions of the slot count.
    always_comb begin
        group  = GW'(int'(slot_reg) % NGRP);
        ch_idx = CW'(int'(slot_reg) % NCH);
    end

    // A pending write lands when its channel sits at the ring head on a cen.
    // Since ch_idx mod NGRP equals the group, only the visited ring is affected.
    assign commit   = cen && busy_reg && (ch_idx == pend_ch_reg);
    assign pend_bad = int'(pend_ch_reg) >= NCH;

    // Slot counter, wrapping at NSLOT-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= '0;
        end else if (cen) begin
            slot_reg <= (slot_reg == SW'(NSLOT - 1)) ? '0 : slot_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_ring
            logic [CHCSRW-1:0] words_reg [STAGES];

            assign heads[gi*CHCSRW +: CHCSRW] = words_reg[0];

            // Rotate this group's ring when it is visited; the tail takes
            // either the recirculated head or the committed write data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        words_reg[i] <= '0;
                    end
                end else if (cen && (group == GW'(gi))) begin
                    for (int i = 0; i < STAGES - 1; i++) begin
                        words_reg[i] <= words_reg[i+1];
                    end
                    words_reg[STAGES-1] <= commit ? pend_data_reg : words_reg[0];
                end
            end
        end
    endgenerate

    // Select the head word of the group being visited.
    always_comb begin
        chcfg = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (group == GW'(g)) begin
                chcfg = heads[g*CHCSRW +: CHCSRW];
            end
        end
    end

    // Write capture and completion; out-of-range channels complete at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            pend_ch_reg   <= '0;
            pend_data_reg <= '0;
        end else begin
            ack_reg <= 1'b0;
            if (!busy_reg) begin
                if (wr_req) begin
                    busy_reg      <= 1'b1;
                    pend_ch_reg   <= wr_ch;
                    pend_data_reg <= wr_din;
                end
            end else if (pend_bad || commit) begin
                busy_reg <= 1'b0;
                ack_reg  <= 1'b1;
            end
        end
    end

    // Rhythm CSR reload at frame end, rotation otherwise; operator enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rhy_csr_reg <= '0;
            rhy_oen_reg <= 1'b0;
        end else if (cen) begin
            if (slot_reg == SW'(NSLOT - 1)) begin
                rhy_csr_reg <= {rhy_kon[4], rhy_kon[0], rhy_kon[2],
                                rhy_kon[4], rhy_kon[3], rhy_kon[1]};
                rhy_oen_reg <= 1'b0;
            end else begin
                rhy_csr_reg <= {rhy_csr_reg[4:0], rhy_csr_reg[5]};
                if (slot_reg == SW'(OEN_SLOT)) begin
                    rhy_oen_reg <= rhy_en;
                end
            end
        end
    end

    assign slot      = slot_reg;
    assign zero      = (slot_reg == '0);
    assign wr_busy   = busy_reg;
    assign wr_ack    = ack_reg;
    assign rhy_oen   = rhy_oen_reg;
    assign rhyon_csr = rhy_csr_reg[5];

endmodule

// File: tb/tb_jtopl_reg_chn.sv
// Self-checking bench for jtopl_reg_chn: a per-channel memory model with a
// queue of pending writes checks every cycle; a second 4x4 instance covers
// the larger configuration.
module tb_jtopl_reg_chn;

    logic       clk = 1'b0;
    logic       rst, cen, rhy_en, wr_req;
    logic [4:0] rhy_kon;
    logic [3:0] wr_ch;
    logic [9:0] wr_din;
    logic       wr_busy, wr_ack, zero, rhy_oen, rhyon_csr;
    logic [4:0] slot;
    logic [3:0] ch_idx;
    logic [9:0] chcfg;

    logic       cen2, wr_req2;
    logic [3:0] wr_ch2;
    logic [9:0] wr_din2;
    logic       wr_busy2, wr_ack2, zero2, rhy_oen2, rhyon_csr2;
    logic [4:0] slot2;
    logic [3:0] ch_idx2;
    logic [9:0] chcfg2;

    always #5 clk = ~clk;

    jtopl_reg_chn dut (
        .clk(clk), .rst(rst), .cen(cen), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
        .wr_req(wr_req), .wr_ch(wr_ch), .wr_din(wr_din),
        .wr_busy(wr_busy), .wr_ack(wr_ack), .slot(slot), .zero(zero),
        .ch_idx(ch_idx), .chcfg(chcfg), .rhy_oen(rhy_oen), .rhyon_csr(rhyon_csr)
    );

    jtopl_reg_chn #(.NGRP(4), .STAGES(4)) dut2 (
        .clk(clk), .rst(rst), .cen(cen2), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
        .wr_req(wr_req2), .wr_ch(wr_ch2), .wr_din(wr_din2),
        .wr_busy(wr_busy2), .wr_ack(wr_ack2), .slot(slot2), .zero(zero2),
        .ch_idx(ch_idx2), .chcfg(chcfg2), .rhy_oen(rhy_oen2), .rhyon_csr(rhyon_csr2)
    );

    typedef struct {
        int ch;
        int data;
    } wr_t;

    wr_t        pq[$];
    int         mem [9];
    int         m_slot;
    bit         m_busy, m_oen, m_loaded;
    logic [5:0] m_pat;
    int         n_checks = 0;
    int         n_errors = 0;
    int         ack2_slot;
    bit         ack2_seen;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model on the pre-edge inputs, then compare.
    task automatic tick();
        bit   exp_ack;
        int   exp_rhy;
        int   pre_slot2;
        wr_t  w;
        exp_ack   = 1'b0;
        pre_slot2 = int'(slot2);
        if (rst) begin
            m_slot = 0; m_busy = 0; m_oen = 0; m_loaded = 0; m_pat = '0;
            pq.delete();
            foreach (mem[i]) mem[i] = 0;
        end else begin
            if (!m_busy) begin
                if (wr_req) begin
                    pq.push_back('{ch: int'(wr_ch), data: int'(wr_din)});
                    m_busy = 1;
                end
            end else if (pq[0].ch >= 9) begin
                m_busy = 0; exp_ack = 1;
            end else if (cen && (m_slot % 9) == pq[0].ch) begin
                m_busy = 0; exp_ack = 1;
            end
            if (cen) begin
                if (m_slot == 17) begin
                    m_pat = {rhy_kon[4], rhy_kon[0], rhy_kon[2], rhy_kon[4], rhy_kon[3], rhy_kon[1]};
                    m_loaded = 1; m_oen = 0;
                end else if (m_slot == 11) begin
                    m_oen = rhy_en;
                end
                m_slot = (m_slot + 1) % 18;
            end
        end
        @(posedge clk);
        #1;
        if (exp_ack) begin
            w = pq.pop_front();
            if (w.ch < 9) mem[w.ch] = w.data;
        end
        exp_rhy = m_loaded ? int'(m_pat[5 - (m_slot % 6)]) : 0;
        check("slot",      int'(slot),      m_slot);
        check("zero",      int'(zero),      int'(m_slot == 0));
        check("ch_idx",    int'(ch_idx),    m_slot % 9);
        check("chcfg",     int'(chcfg),     mem[m_slot % 9]);
        check("wr_busy",   int'(wr_busy),   int'(m_busy));
        check("wr_ack",    int'(wr_ack),    int'(exp_ack));
        check("rhy_oen",   int'(rhy_oen),   int'(m_oen));
        check("rhyon_csr", int'(rhyon_csr), exp_rhy);
        if (wr_ack2) begin
            ack2_seen = 1;
            ack2_slot = pre_slot2;
        end
        $display("t=%0t slot=%0d ch=%0d chcfg=%03h busy=%0b ack=%0b oen=%0b rhy=%0b | slot2=%0d ack2=%0b",
                 $time, slot, ch_idx, chcfg, wr_busy, wr_ack, rhy_oen, rhyon_csr, slot2, wr_ack2);
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        while (m_slot != s && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_slot2(input int s, input string tag);
        int n = 0;
        while (int'(slot2) != s && n < 40) begin
            tick();
            n++;
        end
        if (int'(slot2) != s) check(tag, int'(slot2), s);
    endtask

    // Write ch 15 on the 4x4 instance and check which slot it commits at.
    task automatic write2(input int at_slot, input int exp_slot, input int data);
        int n = 0;
        wait_slot2(at_slot, "slot2_reach");
        wr_req2 = 1; wr_ch2 = 4'd15; wr_din2 = 10'(data);
        ack2_seen = 0;
        tick();
        wr_req2 = 0;
        while (!ack2_seen && n < 40) begin
            tick();
            n++;
        end
        if (!ack2_seen) check("ch15_ack_timeout", 0, 1);
        else            check("ch15_commit_slot", ack2_slot, exp_slot);
        n = 0;
        while (int'(ch_idx2) != 15 && n < 40) begin
            tick();
            n++;
        end
        check("ch15_readback", int'(chcfg2), data);
    endtask

    initial begin
        rst = 1; cen = 0; rhy_en = 0; rhy_kon = '0;
        wr_req = 0; wr_ch = '0; wr_din = '0;
        cen2 = 1; wr_req2 = 0; wr_ch2 = '0; wr_din2 = '0;
        ack2_seen = 0; ack2_slot = 0;
        m_slot = 0; m_busy = 0; m_oen = 0; m_loaded = 0; m_pat = '0;
        foreach (mem[i]) mem[i] = 0;

        repeat (3) tick();
        rst = 0;
        cen = 1;
        repeat (20) tick();

        // ch 4 = 0x2A5 issued at slot 0
        wait_slot(0);
        wr_req = 1; wr_ch = 4'd4; wr_din = 10'h2A5;
        tick();
        wr_req = 0;
        repeat (40) tick();

        // requests while busy are ignored
        wr_req = 1; wr_ch = 4'd2; wr_din = 10'h111;
        tick();
        wr_din = 10'h3FF;
        tick();
        wr_ch = 4'd6; wr_din = 10'h0AA;
        tick();
        wr_req = 0;
        repeat (30) tick();

        // capture on the same edge as the matching visit
        wait_slot(5);
        wr_req = 1; wr_ch = 4'd5; wr_din = 10'h155;
        tick();
        wr_req = 0;
        repeat (25) tick();

        // out-of-range channel
        wr_req = 1; wr_ch = 4'd12; wr_din = 10'h3AB;
        tick();
        wr_req = 0;
        repeat (4) tick();

        // random cen and writes
        repeat (200) begin
            cen    = 1'($urandom_range(0, 1));
            wr_req = ($urandom_range(0, 5) == 0);
            wr_ch  = 4'($urandom_range(0, 10));
            wr_din = 10'($urandom);
            tick();
        end
        cen = 1; wr_req = 0;
        repeat (20) tick();

        // rhythm: BD only, then random key-on patterns
        rhy_kon = 5'b10000; rhy_en = 1;
        repeat (40) tick();
        repeat (3) begin
            rhy_kon = 5'($urandom);
            repeat (18) tick();
        end
        rhy_en = 0;
        repeat (20) tick();

        // reset with ch 7 write pending at slot 2, competing with wr_req
        wait_slot(0);
        wr_req = 1; wr_ch = 4'd7; wr_din = 10'h3C3;
        tick();
        wr_req = 0;
        tick();
        rst = 1; wr_req = 1; wr_ch = 4'd1; wr_din = 10'h001;
        tick();
        rst = 0; wr_req = 0;
        repeat (25) tick();

        // 4x4 instance: wrap and ch 15 commit points
        wait_slot2(31, "slot2_reach31");
        tick();
        check("slot2_wrap", int'(slot2), 0);
        write2(20, 31, 10'h155);
        write2(3, 15, 10'h2DA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jtopl_reg_chn.md
JTOPL_REG_CHN -- requirements
Module: jtopl_reg_chn

Interface
REQ-001 SHALL have parameter CHCSRW, default 10, meaning channel-config word width.
REQ-002 SHALL have parameter NGRP, default 3, meaning number of channel groups (≥2).
REQ-003 SHALL have parameter STAGES, default 3, meaning channels per group (≥2); NCH=NGRP*STAGES, NSLOT=2*NCH, derived.
REQ-004 SHALL have parameter OEN_SLOT, default 11, meaning slot at which rhy_oen samples rhy_en (0..NSLOT-2).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port cen, input, 1, slot-advance enable.
REQ-009 SHALL have port rhy_en, input, 1, rhythm mode enable.
REQ-010 SHALL have port rhy_kon, input, 5, rhythm key-on {BD,SD,TOM,TC,HH} at bits 4..0.
REQ-011 SHALL have port wr_req, input, 1, channel-config write request.
REQ-012 SHALL have port wr_ch, input, clog2(NCH), target channel.
REQ-013 SHALL have port wr_din, input, CHCSRW, write data.
REQ-014 SHALL have port wr_busy, output, 1, write pending.
REQ-015 SHALL have port wr_ack, output, 1, one-clk commit pulse.
REQ-016 SHALL have port slot, output, clog2(NSLOT), current slot count.
REQ-017 SHALL have port zero, output, 1, high while slot==0.
REQ-018 SHALL have port ch_idx, output, clog2(NCH), channel at ring head.
REQ-019 SHALL have port chcfg, output, CHCSRW, config of channel ch_idx.
REQ-020 SHALL have port rhy_oen, output, 1, rhythm operator enable.
REQ-021 SHALL have port rhyon_csr, output, 1, rhythm key-on for current slot.

Function
REQ-022 SHALL increment slot on each clk with cen high, wrapping NSLOT-1 -> 0; no change when cen low.
REQ-023 SHALL derive group = slot mod NGRP and ch_idx = slot mod NCH, combinationally.
REQ-024 SHALL hold NGRP circular rings of STAGES words each; only the ring of the current group rotates one position per cen.
REQ-025 SHALL drive chcfg from the head word of the current group's ring, combinationally (no added latency).
REQ-026 SHALL capture wr_ch/wr_din and set wr_busy on a clk where wr_req=1 and wr_busy=0, cen-independent.
REQ-027 SHALL ignore wr_req while wr_busy=1; pending data remains unchanged.
REQ-028 SHALL commit on the first cen clk with wr_busy=1 and ch_idx==pending channel: the head word re-enters the ring as pending data instead of recirculating.
REQ-029 SHALL, on the commit edge, clear wr_busy and pulse wr_ack for exactly one clk.
REQ-030 SHALL show the old value on chcfg during the commit cycle and the new value from the channel's next visit (NCH cens later).
REQ-031 SHALL commit within at most NCH cens of capture; a capture on the same clk as a matching cen SHALL NOT commit until that channel's next visit.
REQ-032 SHALL treat wr_ch ≥ NCH as a no-op: wr_ack pulses on the clk after capture, with no ring change.
REQ-033 SHALL, on cen with slot==NSLOT-1, load the 6-bit rhythm CSR with {BD,HH,TOM,BD,SD,TC} and clear rhy_oen.
REQ-034 SHALL otherwise rotate the rhythm CSR left by one (bit5 -> bit0) on each cen.
REQ-035 SHALL drive rhyon_csr from rhythm CSR bit 5.
REQ-036 SHALL load rhy_oen from rhy_en on cen with slot==OEN_SLOT; otherwise hold it.

Reset
REQ-037 SHALL, on rst, clear all ring words, slot, rhythm CSR, rhy_oen, wr_busy, wr_ack, and pending data.
REQ-038 SHALL drop a pending write on rst without asserting wr_ack.
REQ-039 SHALL give rst priority over cen and wr_req on the same clk.

Verification
REQ-040 Defaults, continuous cen after reset: slot counts 0..17 and wraps; zero is high at slot 0 only; ch_idx runs 0..8,0..8.
REQ-041 Write ch 4 = 0x2A5 at slot 0: wr_ack at the cen with slot 4; chcfg=0x000 that cycle; chcfg=0x2A5 at slot 13 and on every later visit to ch 4.
REQ-042 Second wr_req while busy: ignored; only the first data commits, with one wr_ack.
REQ-043 rhy_kon=5'b10000, rhy_en=1: rhyon_csr high at slots 0 and 3 of the next frame; rhy_oen rises after the slot-11 cen and falls after the slot-17 cen.
REQ-044 rst asserted at slot 2 with a write to ch 7 pending: wr_busy=0, no wr_ack, ch 7 reads 0x000, slot restarts at 0.
REQ-045 NGRP=4, STAGES=4: 32-slot wrap; write to ch 15 commits at slot 15 or 31, whichever comes first.
